// File: rtl/i2c_master_core.sv
// I2C master byte engine: START, address, write, read and STOP sequencing.
// Quarter-bit timing from a tick divider; open-drain style line outputs.
module i2c_master_core (
    input  logic       aclk,
    input  logic       areset,
    input  logic       enable,
    input  logic       cmd_start,
    input  logic       cmd_write,
    input  logic       cmd_read,
    input  logic       cmd_stop,
    input  logic       master_ack,
    input  logic [7:0] tx_data,
    input  logic [6:0] slave_addr,
    input  logic [7:0] clk_div,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       sda_o,
    output logic       busy,
    output logic       error,
    output logic [7:0] rx_data,
    output logic       rx_valid
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_BIT   = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [7:0] cnt_q, cnt_d;
    logic [2:0] st_q, st_d;
    logic [1:0] qtr_q, qtr_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] byte_q, byte_d;
    logic       rd_q, rd_d;
    logic       ack_q, ack_d;
    logic [7:0] rxsh_q, rxsh_d;
    logic       scl_q, scl_d;
    logic       sda_q, sda_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;
    logic [7:0] rx_q, rx_d;
    logic       rxv_q, rxv_d;
    logic       cs_q, cw_q, cr_q, cp_q;

    logic tick;
    logic e_s, e_w, e_r, e_p;
    logic p_s, p_w, p_r, p_p;
    logic accept;
    logic abort;
    logic adv;
    logic upd;
    logic lv_scl, lv_sda;

    // Tick when the divider count reaches clk_div; >= covers a shrinking clk_div.
    assign tick = (cnt_q >= clk_div);

    assign e_s = cmd_start & ~cs_q;
    assign e_w = cmd_write & ~cw_q;
    assign e_r = cmd_read  & ~cr_q;
    assign e_p = cmd_stop  & ~cp_q;

    // One-hot priority: start > write > read > stop.
    assign p_s = e_s;
    assign p_w = e_w & ~e_s;
    assign p_r = e_r & ~e_s & ~e_w;
    assign p_p = e_p & ~e_s & ~e_w & ~e_r;

    assign accept = (st_q == S_IDLE) && enable && (e_s | e_w | e_r | e_p);
    assign abort  = (st_q != S_IDLE) && !enable;
    assign adv    = (st_q != S_IDLE) && enable && tick;

    // Sequencer: command acceptance, abort and quarter/bit stepping.
    always_comb begin
        cnt_d  = (tick || accept) ? 8'd0 : cnt_q + 8'd1;
        st_d   = st_q;
        qtr_d  = qtr_q;
        bit_d  = bit_q;
        byte_d = byte_q;
        rd_d   = rd_q;
        ack_d  = ack_q;
        rxsh_d = rxsh_q;
        busy_d = busy_q;
        err_d  = err_q;
        rx_d   = rx_q;
        rxv_d  = 1'b0;
        upd    = 1'b0;
        if (accept) begin
            busy_d = 1'b1;
            qtr_d  = 2'd0;
            bit_d  = 3'd0;
            ack_d  = master_ack;
            upd    = 1'b1;
            unique case (1'b1)
                p_s: begin
                    st_d   = S_START;
                    byte_d = {slave_addr, cmd_read};
                    rd_d   = 1'b0;
                    err_d  = 1'b0;
                end
                p_w: begin
                    st_d   = S_BIT;
                    byte_d = tx_data;
                    rd_d   = 1'b0;
                end
                p_r: begin
                    st_d = S_BIT;
                    rd_d = 1'b1;
                end
                p_p: begin
                    st_d = S_STOP;
                end
                default: begin
                    st_d = S_IDLE;
                end
            endcase
        end else if (abort) begin
            st_d   = S_IDLE;
            busy_d = 1'b0;
        end else if (adv) begin
            upd   = 1'b1;
            qtr_d = qtr_q + 2'd1;
            case (st_q)
                S_START: begin
                    if (qtr_q == 2'd3) begin
                        st_d  = S_BIT;
                        bit_d = 3'd0;
                    end
                end
                S_BIT: begin
                    if (qtr_q == 2'd2 && rd_q)
                        rxsh_d = {rxsh_q[6:0], sda_i};
                    if (qtr_q == 2'd3) begin
                        if (bit_q == 3'd7)
                            st_d = S_ACK;
                        else
                            bit_d = bit_q + 3'd1;
                    end
                end
                S_ACK: begin
                    if (qtr_q == 2'd2 && !rd_q && sda_i)
                        err_d = 1'b1;
                    if (qtr_q == 2'd3) begin
                        st_d   = S_IDLE;
                        busy_d = 1'b0;
                        upd    = 1'b0;
                        if (rd_q) begin
                            rx_d  = rxsh_q;
                            rxv_d = 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (qtr_q == 2'd3) begin
                        st_d   = S_IDLE;
                        busy_d = 1'b0;
                        upd    = 1'b0;
                    end
                end
                default: begin
                    st_d = S_IDLE;
                end
            endcase
        end
    end

    // Line levels for the position being entered.
    always_comb begin
        lv_scl = scl_q;
        lv_sda = sda_q;
        case (st_d)
            S_START: begin
                lv_scl = (qtr_d == 2'd0) || (qtr_d == 2'd1);
                lv_sda = (qtr_d == 2'd0);
            end
            S_BIT: begin
                lv_scl = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                lv_sda = rd_d ? 1'b1 : byte_d[~bit_d];
            end
            S_ACK: begin
                lv_scl = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                lv_sda = rd_d ? ~ack_d : 1'b1;
            end
            S_STOP: begin
                lv_scl = (qtr_d != 2'd0);
                lv_sda = qtr_d[1];
            end
            default: begin
                lv_scl = scl_q;
                lv_sda = sda_q;
            end
        endcase
    end

    // Abort releases both lines; otherwise lines only move on a step.
    always_comb begin
        scl_d = scl_q;
        sda_d = sda_q;
        if (abort) begin
            scl_d = 1'b1;
            sda_d = 1'b1;
        end else if (upd) begin
            scl_d = lv_scl;
            sda_d = lv_sda;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_q  <= 8'd0;
            st_q   <= S_IDLE;
            qtr_q  <= 2'd0;
            bit_q  <= 3'd0;
            byte_q <= 8'd0;
            rd_q   <= 1'b0;
            ack_q  <= 1'b0;
            rxsh_q <= 8'd0;
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
            rx_q   <= 8'd0;
            rxv_q  <= 1'b0;
            cs_q   <= 1'b0;
            cw_q   <= 1'b0;
            cr_q   <= 1'b0;
            cp_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            st_q   <= st_d;
            qtr_q  <= qtr_d;
            bit_q  <= bit_d;
            byte_q <= byte_d;
            rd_q   <= rd_d;
            ack_q  <= ack_d;
            rxsh_q <= rxsh_d;
            scl_q  <= scl_d;
            sda_q  <= sda_d;
            busy_q <= busy_d;
            err_q  <= err_d;
            rx_q   <= rx_d;
            rxv_q  <= rxv_d;
            cs_q   <= cmd_start;
            cw_q   <= cmd_write;
            cr_q   <= cmd_read;
            cp_q   <= cmd_stop;
        end
    end

    assign scl_o    = scl_q;
    assign sda_o    = sda_q;
    assign busy     = busy_q;
    assign error    = err_q;
    assign rx_data  = rx_q;
    assign rx_valid = rxv_q;

endmodule
